// File: rtl/d_mem_access_ctrl_rv_pkg.sv
// Shared encodings and load-extraction helpers for the data-memory access controller.
package d_mem_access_ctrl_rv_pkg;

  typedef enum logic [1:0] {
    MEM_ACCESS_NONE      = 2'd0,
    MEM_ACCESS_BYTE      = 2'd1,
    MEM_ACCESS_HALF_WORD = 2'd2,
    MEM_ACCESS_WORD      = 2'd3
  } mem_access_e;

  typedef enum logic [1:0] {
    D_MEM_CTRL_ST_IDLE  = 2'd0,
    D_MEM_CTRL_ST_BUS   = 2'd1,
    D_MEM_CTRL_ST_RESP  = 2'd2,
    D_MEM_CTRL_ST_FAULT = 2'd3
  } d_mem_ctrl_st_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      MEM_ACCESS_HALF_WORD: return addr_lo[0];
      MEM_ACCESS_WORD:      return |addr_lo;
      default:              return 1'b0;
    endcase
  endfunction

  // Lane select by shifting the addressed byte down to bit 0, then extend.
  function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] addr_lo,
                                               input logic [1:0] size, input logic sign);
    logic [31:0] sh;
    sh = rdata >> {addr_lo, 3'b000};
    case (size)
      MEM_ACCESS_BYTE:      return {{24{sign & sh[7]}}, sh[7:0]};
      MEM_ACCESS_HALF_WORD: return {{16{sign & sh[15]}}, sh[15:0]};
      MEM_ACCESS_WORD:      return rdata;
      default:              return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/d_mem_access_ctrl_rv_write.sv
// Store lane builder: byte enables and replicated-lane write data from address, size and data.
module d_mem_access_ctrl_rv_write
  import d_mem_access_ctrl_rv_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_data,
  output logic [3:0]  o_byte_en,
  output logic [31:0] o_lane_data
);

  always_comb begin
    o_byte_en   = 4'b0000;
    o_lane_data = 32'd0;
    case (i_size)
      MEM_ACCESS_BYTE: begin
        o_byte_en   = 4'b0001 << i_addr_lo;
        o_lane_data = {4{i_data[7:0]}};
      end
      MEM_ACCESS_HALF_WORD: begin
        o_byte_en   = 4'b0011 << i_addr_lo;
        o_lane_data = {2{i_data[15:0]}};
      end
      MEM_ACCESS_WORD: begin
        o_byte_en   = 4'b1111;
        o_lane_data = i_data;
      end
      default: begin
        o_byte_en   = 4'b0000;
        o_lane_data = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/d_mem_access_ctrl_rv.sv
// Data-memory access controller: sequences one load/store at a time onto a req/ack word bus,
// flags misalignment and bus timeouts, and returns a single-cycle response per accepted request.
module d_mem_access_ctrl_rv
  import d_mem_access_ctrl_rv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
)
(
  input  logic        iwClk,
  input  logic        iwRst,
  input  logic        iwReqValid,
  output logic        owReqReady,
  input  logic [31:0] iwAddress,
  input  logic [1:0]  iwDMemAccess,
  input  logic        iwDMemSignExtend,
  input  logic        iwWrite,
  input  logic [31:0] iwWriteData,
  output logic        owBusReq,
  output logic        owBusWrite,
  output logic [31:0] owBusAddress,
  output logic [3:0]  owBusByteEn,
  output logic [31:0] owBusWData,
  input  logic        iwBusAck,
  input  logic [31:0] iwBusRData,
  output logic        owRespValid,
  output logic [31:0] owRespData,
  output logic        owMisaligned,
  output logic        owBusError,
  output logic        owBusy
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  d_mem_ctrl_st_e    r_state;
  d_mem_ctrl_st_e    w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_bus_err;
  logic [31:0]       r_addr;
  logic [1:0]        r_size;
  logic              r_sign;
  logic              r_write;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              w_accept;
  logic [3:0]        w_byte_en;
  logic [31:0]       w_lane_data;

  assign w_accept = iwReqValid & (r_state == D_MEM_CTRL_ST_IDLE);

  // State, timeout counter and fault cause are reset; captured request/read fields are not.
  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      r_state   <= D_MEM_CTRL_ST_IDLE;
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == D_MEM_CTRL_ST_BUS) begin
        if (r_cnt != CNT_LAST) r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
      if (w_next_state == D_MEM_CTRL_ST_FAULT)
        r_bus_err <= (r_state == D_MEM_CTRL_ST_BUS);
    end
    if (w_accept) begin
      r_addr  <= iwAddress;
      r_size  <= iwDMemAccess;
      r_sign  <= iwDMemSignExtend;
      r_write <= iwWrite;
      r_wdata <= iwWriteData;
    end
    if ((r_state == D_MEM_CTRL_ST_BUS) && iwBusAck) r_rdata <= iwBusRData;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      D_MEM_CTRL_ST_IDLE: begin
        if (w_accept) begin
          if (is_misaligned(iwDMemAccess, iwAddress[1:0]))
            w_next_state = D_MEM_CTRL_ST_FAULT;
          else if (iwDMemAccess == MEM_ACCESS_NONE)
            w_next_state = D_MEM_CTRL_ST_RESP;
          else
            w_next_state = D_MEM_CTRL_ST_BUS;
        end
      end
      // Ack wins over timeout when both land on the last allowed cycle.
      D_MEM_CTRL_ST_BUS: begin
        if (iwBusAck)
          w_next_state = D_MEM_CTRL_ST_RESP;
        else if (r_cnt == CNT_LAST)
          w_next_state = D_MEM_CTRL_ST_FAULT;
      end
      D_MEM_CTRL_ST_RESP:  w_next_state = D_MEM_CTRL_ST_IDLE;
      D_MEM_CTRL_ST_FAULT: w_next_state = D_MEM_CTRL_ST_IDLE;
      default:             w_next_state = D_MEM_CTRL_ST_IDLE;
    endcase
  end

  d_mem_access_ctrl_rv_write u_write (
    .i_addr_lo   (r_addr[1:0]),
    .i_size      (r_size),
    .i_data      (r_wdata),
    .o_byte_en   (w_byte_en),
    .o_lane_data (w_lane_data)
  );

  always_comb begin
    owReqReady   = 1'b0;
    owBusReq     = 1'b0;
    owBusWrite   = 1'b0;
    owBusAddress = 32'd0;
    owBusByteEn  = 4'b0000;
    owBusWData   = 32'd0;
    owRespValid  = 1'b0;
    owRespData   = 32'd0;
    owMisaligned = 1'b0;
    owBusError   = 1'b0;
    owBusy       = 1'b1;
    case (r_state)
      D_MEM_CTRL_ST_IDLE: begin
        owReqReady = 1'b1;
        owBusy     = 1'b0;
      end
      D_MEM_CTRL_ST_BUS: begin
        owBusReq     = 1'b1;
        owBusWrite   = r_write;
        owBusAddress = {r_addr[31:2], 2'b00};
        owBusByteEn  = r_write ? w_byte_en : 4'b1111;
        owBusWData   = r_write ? w_lane_data : 32'd0;
      end
      D_MEM_CTRL_ST_RESP: begin
        owRespValid = 1'b1;
        owRespData  = r_write ? 32'd0 : load_extend(r_rdata, r_addr[1:0], r_size, r_sign);
      end
      D_MEM_CTRL_ST_FAULT: begin
        owRespValid  = 1'b1;
        owMisaligned = ~r_bus_err;
        owBusError   = r_bus_err;
      end
      default: owBusy = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_d_mem_access_ctrl_rv.sv
// Directed bench for d_mem_access_ctrl_rv with a transaction-level reference model checked every cycle.
module tb_d_mem_access_ctrl_rv;
  import d_mem_access_ctrl_rv_pkg::*;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst;
  logic        valid;
  logic        owReqReady;
  logic [31:0] addr;
  logic [1:0]  size;
  logic        sign;
  logic        wr;
  logic [31:0] wdata;
  logic        owBusReq;
  logic        owBusWrite;
  logic [31:0] owBusAddress;
  logic [3:0]  owBusByteEn;
  logic [31:0] owBusWData;
  logic        ack;
  logic [31:0] rdata;
  logic        owRespValid;
  logic [31:0] owRespData;
  logic        owMisaligned;
  logic        owBusError;
  logic        owBusy;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  int ack_after = -1;
  int bus_cnt   = 0;
  bit ack_force = 0;

  d_mem_access_ctrl_rv #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .iwClk(clk), .iwRst(rst), .iwReqValid(valid), .owReqReady(owReqReady),
    .iwAddress(addr), .iwDMemAccess(size), .iwDMemSignExtend(sign), .iwWrite(wr),
    .iwWriteData(wdata), .owBusReq(owBusReq), .owBusWrite(owBusWrite),
    .owBusAddress(owBusAddress), .owBusByteEn(owBusByteEn), .owBusWData(owBusWData),
    .iwBusAck(ack), .iwBusRData(rdata), .owRespValid(owRespValid), .owRespData(owRespData),
    .owMisaligned(owMisaligned), .owBusError(owBusError), .owBusy(owBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    case (s)
      2'd1:    return 1;
      2'd2:    return 2;
      2'd3:    return 4;
      default: return 0;
    endcase
  endfunction

  // Gather nb bytes starting at byte lane lo, then extend from the top gathered byte.
  function automatic logic [31:0] m_load(input logic [31:0] w, input int lo, input int nb, input logic sg);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < nb; i++) r[8*i +: 8] = w[8*(lo+i) +: 8];
    if (sg && nb > 0 && nb < 4 && r[8*nb-1])
      for (int i = nb; i < 4; i++) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  // Reference model: one outstanding transaction, described by phase flags.
  bit          m_busy, m_onbus, m_resp, m_mis, m_berr;
  logic [31:0] m_data, ma, mwd;
  int          m_wait, mnb;
  logic        msg, mwr;

  initial begin
    m_busy = 0; m_onbus = 0; m_resp = 0; m_mis = 0; m_berr = 0;
    m_data = 0; ma = 0; mwd = 0; m_wait = 0; mnb = 0; msg = 0; mwr = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_busy = 0; m_onbus = 0; m_resp = 0; m_mis = 0; m_berr = 0; m_data = 0;
      end else if (m_resp) begin
        m_busy = 0; m_resp = 0; m_mis = 0; m_berr = 0; m_data = 0;
      end else if (m_onbus) begin
        if (ack) begin
          m_onbus = 0; m_resp = 1;
          m_data  = mwr ? 32'd0 : m_load(rdata, int'(ma[1:0]), mnb, msg);
        end else begin
          m_wait++;
          if (m_wait >= TIMEOUT) begin
            m_onbus = 0; m_resp = 1; m_berr = 1; m_data = 0;
          end
        end
      end else if (valid) begin
        ma = addr; mnb = nbytes(size); msg = sign; mwr = wr; mwd = wdata;
        m_busy = 1; m_data = 0;
        if (mnb == 0) m_resp = 1;
        else if ((int'(ma[1:0]) % mnb) != 0) begin m_resp = 1; m_mis = 1; end
        else begin m_onbus = 1; m_wait = 0; end
      end
    end
  end

  // Per-cycle compare of every output against the model.
  initial forever begin
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    @(negedge clk);
    if (chk_en) begin
      e_be = 4'b0000;
      e_wd = 32'd0;
      if (m_onbus) begin
        if (mwr) begin
          for (int n = 0; n < 4; n++) begin
            e_be[n] = (n >= int'(ma[1:0])) && (n < int'(ma[1:0]) + mnb);
            e_wd[8*n +: 8] = mwd[8*(n % mnb) +: 8];
          end
        end else e_be = 4'b1111;
      end
      chk("ready",    {31'd0, owReqReady},   {31'd0, !m_busy});
      chk("busy",     {31'd0, owBusy},       {31'd0, m_busy});
      chk("busreq",   {31'd0, owBusReq},     {31'd0, m_onbus});
      chk("buswrite", {31'd0, owBusWrite},   {31'd0, m_onbus && mwr});
      chk("busaddr",  owBusAddress,          m_onbus ? (ma & 32'hFFFF_FFFC) : 32'd0);
      chk("byteen",   {28'd0, owBusByteEn},  {28'd0, e_be});
      chk("buswdata", owBusWData,            e_wd);
      chk("respvld",  {31'd0, owRespValid},  {31'd0, m_resp});
      chk("respdata", owRespData,            m_resp ? m_data : 32'd0);
      chk("misalign", {31'd0, owMisaligned}, {31'd0, m_resp && m_mis});
      chk("buserr",   {31'd0, owBusError},   {31'd0, m_resp && m_berr});
    end
  end

  // Bus slave: acks on the (ack_after)-th cycle of each bus request, counted from 0.
  initial begin
    ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (owBusReq) begin
        ack = (bus_cnt == ack_after) || ack_force;
        bus_cnt++;
      end else begin
        ack = ack_force;
        bus_cnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [1:0] s, input logic sg, input logic w,
                       input logic [31:0] d);
    bit ok;
    ok = 0;
    addr = a; size = s; sign = sg; wr = w; wdata = d; valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (owReqReady) begin ok = 1; break; end
    end
    if (!ok) begin n_tests++; n_fail++; $display("FAIL accept_timeout addr %h", a); end
    step();
    valid = 1'b0;
  endtask

  task automatic wait_resp(input int maxc, output int lat, output int nreq,
                           output logic [3:0] be0, output logic [31:0] wd0, output logic [31:0] ad0);
    lat = 0; nreq = 0; be0 = 0; wd0 = 0; ad0 = 0;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge clk);
      if (owBusReq) begin
        if (nreq == 0) begin be0 = owBusByteEn; wd0 = owBusWData; ad0 = owBusAddress; end
        nreq++;
      end
      if (owRespValid) begin lat = k; break; end
    end
    if (lat == 0) begin n_tests++; n_fail++; $display("FAIL resp_timeout got none within %0d", maxc); end
  endtask

  task automatic run_vec(input string nm, input logic [31:0] a, input logic [1:0] s, input logic sg,
                         input logic w, input logic [31:0] d, input logic [31:0] rd, input int aa,
                         input int e_lat, input logic [31:0] e_data, input logic e_mis);
    int lat, nreq;
    logic [3:0] be0;
    logic [31:0] wd0, ad0;
    rdata = rd; ack_after = aa;
    issue(a, s, sg, w, d);
    wait_resp(64, lat, nreq, be0, wd0, ad0);
    chk({nm, "_lat"},  lat, e_lat);
    chk({nm, "_data"}, owRespData, e_data);
    chk({nm, "_mis"},  {31'd0, owMisaligned}, {31'd0, e_mis});
    chk({nm, "_berr"}, {31'd0, owBusError}, 32'd0);
  endtask

  initial begin
    int lat, nreq, nrdy;
    bit seen;
    logic [3:0] be0;
    logic [31:0] wd0, ad0;
    rst = 1'b1; valid = 1'b0; addr = 0; size = 0; sign = 0; wr = 0; wdata = 0; rdata = 0;
    step();
    chk_en = 1;
    step(); step();
    @(negedge clk);
    chk("rst_ready",  {31'd0, owReqReady}, 32'd1);
    chk("rst_busreq", {31'd0, owBusReq},   32'd0);
    chk("rst_resp",   {31'd0, owRespValid}, 32'd0);
    rst = 1'b0;

    run_vec("lb_sext",   32'h103, MEM_ACCESS_BYTE,      1, 0, 0, 32'h80FF_1234, 0, 2, 32'hFFFF_FF80, 0);
    run_vec("lw_mis",    32'h6,   MEM_ACCESS_WORD,      0, 0, 0, 0,             0, 1, 32'h0,         1);
    run_vec("lh_sext",   32'h2,   MEM_ACCESS_HALF_WORD, 1, 0, 0, 32'h8001_7FFF, 1, 3, 32'hFFFF_8001, 0);
    run_vec("lbu",       32'h1,   MEM_ACCESS_BYTE,      0, 0, 0, 32'h0000_F000, 0, 2, 32'h0000_00F0, 0);
    run_vec("none",      32'h3,   MEM_ACCESS_NONE,      0, 0, 0, 0,             0, 1, 32'h0,         0);
    run_vec("lh_mis",    32'h11,  MEM_ACCESS_HALF_WORD, 0, 0, 0, 0,             0, 1, 32'h0,         1);
    run_vec("sw",        32'h20,  MEM_ACCESS_WORD,      0, 1, 32'hDEAD_BEEF, 0, 0, 2, 32'h0,         0);
    run_vec("lw",        32'h8,   MEM_ACCESS_WORD,      0, 0, 0, 32'hCAFE_F00D, 3, 5, 32'hCAFE_F00D, 0);
    run_vec("lb_pos",    32'h2,   MEM_ACCESS_BYTE,      1, 0, 0, 32'h007F_0000, 0, 2, 32'h0000_007F, 0);

    // Half-word store lane placement.
    ack_after = 2;
    issue(32'h202, MEM_ACCESS_HALF_WORD, 0, 1, 32'h0000_BEEF);
    wait_resp(64, lat, nreq, be0, wd0, ad0);
    chk("sh_be",   {28'd0, be0}, 32'h0000_000C);
    chk("sh_wd",   wd0, 32'hBEEF_BEEF);
    chk("sh_addr", ad0, 32'h0000_0200);
    chk("sh_lat",  lat, 4);
    chk("sh_nreq", nreq, 3);

    // Timeout on an unacknowledged half-word load.
    ack_after = -1;
    issue(32'h4, MEM_ACCESS_HALF_WORD, 0, 0, 0);
    wait_resp(64, lat, nreq, be0, wd0, ad0);
    chk("to_nreq", nreq, 16);
    chk("to_lat",  lat, 17);
    chk("to_berr", {31'd0, owBusError}, 32'd1);
    chk("to_mis",  {31'd0, owMisaligned}, 32'd0);
    @(negedge clk);
    chk("to_idle", {31'd0, owReqReady}, 32'd1);

    // Back-to-back: store acked on its last allowed cycle, load held pending behind it.
    ack_after = 15;
    issue(32'h301, MEM_ACCESS_BYTE, 0, 1, 32'h1234_56A5);
    addr = 32'h8; size = MEM_ACCESS_WORD; sign = 0; wr = 0; wdata = 0; valid = 1'b1;
    seen = 0; nrdy = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (owReqReady) break;
      nrdy++;
      if (owRespValid) begin
        seen = 1;
        chk("b2b_sb_berr", {31'd0, owBusError}, 32'd0);
        ack_after = 0; rdata = 32'h0BAD_CAFE;
      end
    end
    chk("b2b_notready", nrdy, 17);
    chk("b2b_seen",     {31'd0, seen}, 32'd1);
    step();
    valid = 1'b0;
    wait_resp(64, lat, nreq, be0, wd0, ad0);
    chk("b2b_lw_lat",  lat, 2);
    chk("b2b_lw_data", owRespData, 32'h0BAD_CAFE);

    // Reset while a bus cycle is outstanding.
    ack_after = 5;
    issue(32'h10, MEM_ACCESS_WORD, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_busreq", {31'd0, owBusReq},    32'd0);
    chk("rstmid_resp",   {31'd0, owRespValid}, 32'd0);
    chk("rstmid_ready",  {31'd0, owReqReady},  32'd1);
    rst = 1'b0;
    ack_force = 1;
    @(negedge clk);
    chk("late_ack_resp", {31'd0, owRespValid}, 32'd0);
    @(negedge clk);
    chk("late_ack_busy", {31'd0, owBusy}, 32'd0);
    ack_force = 0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
